regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Architectural register file and writeback result selection for the 5-stage RV32I pipeline. Consumes the W-stage bundle from the MEM/WB pipeline register, selects the result, and commits it to x1–x31. Serves the two Decode-stage read ports. Internal write-to-read bypass lets an instruction in Decode see a value being written back in the same cycle, so the hazard unit needs no WB→D forwarding path.

## Interface
- word_width, 32, data width of registers, results and read ports
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- RegWriteW  in  1  write enable for the W-stage instruction
- ResultSrcW  in  2  result select: 00 ALUResultW, 01 ReadDataW, 10 PCPlus4W, 11 ALUResultW
- ALUResultW  in  word_width  ALU result
- ReadDataW  in  word_width  load data
- PCPlus4W  in  word_width  link address for JAL/JALR
- RdW  in  5  destination register index
- A1D  in  5  Decode read address, port 1 (rs1)
- A2D  in  5  Decode read address, port 2 (rs2)
- RD1D  out  word_width  read data, port 1
- RD2D  out  word_width  read data, port 2
- ResultW  out  word_width  selected writeback result, exported for Execute-stage forwarding
- WriteActiveW  out  1  high when a commit to a nonzero register is occurring this cycle

## Operation
- Storage: 31 registers x1–x31, word_width bits each. x0 has no storage and always reads 0.
- ResultW is combinational from ResultSrcW and the three data inputs. Encoding 11 aliases ALUResultW and is never X.
- WriteActiveW = RegWriteW & (RdW != 0) & !reset.
- Commit: on the rising edge with WriteActiveW high, reg[RdW] <= ResultW. Writes to x0 are discarded silently.
- Reads are combinational per port, evaluated in this order:
  1. reset high: 0.
  2. address 0: 0.
  3. WriteActiveW and address == RdW: ResultW (bypass).
  4. Otherwise: reg[address].
- Both ports may address the same register. Both may hit the bypass in the same cycle.
- Reset: on the rising edge with reset high, x1–x31 clear to 0 and any pending write is dropped. A reset asserted mid-program discards the W-stage instruction in that cycle.
- No stall or enable input. The upstream pipeline register holds W-stage inputs stable. If the same write is repeated, it rewrites the same value and is harmless.

## Timing
- Reset values: RD1D = RD2D = 0 and WriteActiveW = 0 while reset is high. ResultW tracks its inputs regardless of reset. All registers read 0 in the first cycle after reset deasserts.
- Write latency: a value presented in cycle N is visible through the bypass in cycle N and from storage from cycle N+1.
- Read-to-output is purely combinational, with zero cycles of latency.
- Back-to-back writes to the same register in cycles N and N+1: cycle N+1 reads return the N+1 value via bypass. Cycle N+2 reads return the N+1 value from storage.
- Critical path: ResultSrcW mux → bypass compare/mux → RD1D/RD2D. The bypass comparison uses only RdW/RegWriteW/A*D and is independent of the data path.

## Test plan
- Reset clear: preload x5 = 0x1234, assert reset one cycle, then read A1D = 5 → RD1D = 0. RD1D and RD2D also read 0 throughout the reset cycle.
- Result select and commit: present ALUResultW = 0xA, ReadDataW = 0xB, PCPlus4W = 0xC with RdW = 3. Cycle through ResultSrcW 00/01/10/11 on successive writes and read x3 the next cycle each time → 0xA, 0xB, 0xC, 0xA.
- x0 immunity: RegWriteW = 1, RdW = 0, ALUResultW = 0xFFFFFFFF → WriteActiveW = 0. Same cycle and the next, A1D = A2D = 0 → 0.
- Same-cycle bypass: x7 holds 0x11. Write 0x22 to x7 with A1D = A2D = 7 in the same cycle → both ports read 0x22 that cycle. Next cycle with RegWriteW = 0 → 0x22 from storage.
- Write disabled: RegWriteW = 0, RdW = 9, ALUResultW = 0x99, A1D = 9; x9 holds 0x1 → RD1D = 0x1 that cycle and the next.
- Reset mid-write: RegWriteW = 1, RdW = 4, ALUResultW = 0x55, with reset high the same cycle → x4 reads 0 after reset deasserts.

Source files
------------

// File: rtl/regfile_writeback_if.sv
// Writeback bundle and Decode read ports for the architectural register file.
// The master drives the W-stage bundle and read addresses; the slave is the register file.
interface regfile_writeback_if #(
    parameter int unsigned word_width = 32
);
    logic                  RegWriteW;
    logic [1:0]            ResultSrcW;
    logic [word_width-1:0] ALUResultW;
    logic [word_width-1:0] ReadDataW;
    logic [word_width-1:0] PCPlus4W;
    logic [4:0]            RdW;
    logic [4:0]            A1D;
    logic [4:0]            A2D;
    logic [word_width-1:0] RD1D;
    logic [word_width-1:0] RD2D;
    logic [word_width-1:0] ResultW;
    logic                  WriteActiveW;

    modport master (
        output RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW, A1D, A2D,
        input  RD1D, RD2D, ResultW, WriteActiveW
    );

    modport slave (
        input  RegWriteW, ResultSrcW, ALUResultW, ReadDataW, PCPlus4W, RdW, A1D, A2D,
        output RD1D, RD2D, ResultW, WriteActiveW
    );
endinterface

// File: rtl/regfile_writeback.sv
// RV32I register file x1-x31 with writeback result select and same-cycle
// write-to-read bypass on both Decode read ports.
module regfile_writeback #(
    parameter int unsigned word_width = 32
) (
    input logic               clk,
    input logic               reset,
    regfile_writeback_if.slave wb
);
    logic [word_width-1:0] regs_q [1:31];
    logic                  write_active;
    logic                  hit1;
    logic                  hit2;

    always_comb begin
        unique case (wb.ResultSrcW)
            2'b01:   wb.ResultW = wb.ReadDataW;
            2'b10:   wb.ResultW = wb.PCPlus4W;
            default: wb.ResultW = wb.ALUResultW;
        endcase
    end

    assign write_active    = wb.RegWriteW && (wb.RdW != 5'd0) && !reset;
    assign wb.WriteActiveW = write_active;

    // Bypass compare uses only control/address signals, keeping it off the data path.
    assign hit1 = write_active && (wb.A1D == wb.RdW);
    assign hit2 = write_active && (wb.A2D == wb.RdW);

    always_comb begin
        wb.RD1D = '0;
        if (reset || wb.A1D == 5'd0) begin
            wb.RD1D = '0;
        end else if (hit1) begin
            wb.RD1D = wb.ResultW;
        end else begin
            wb.RD1D = regs_q[wb.A1D];
        end
    end

    always_comb begin
        wb.RD2D = '0;
        if (reset || wb.A2D == 5'd0) begin
            wb.RD2D = '0;
        end else if (hit2) begin
            wb.RD2D = wb.ResultW;
        end else begin
            wb.RD2D = regs_q[wb.A2D];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write_active) begin
            regs_q[wb.RdW] <= wb.ResultW;
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed vector table plus randomized run against an array-based register model.
module tb_regfile_writeback;
    localparam int unsigned W = 32;

    logic clk;
    logic reset;

    regfile_writeback_if #(.word_width(W)) bus ();

    regfile_writeback #(.word_width(W)) dut (
        .clk   (clk),
        .reset (reset),
        .wb    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         we;
        logic [1:0]   src;
        logic [W-1:0] alu;
        logic [W-1:0] rdata;
        logic [W-1:0] pc4;
        logic [4:0]   rd;
        logic [4:0]   a1;
        logic [4:0]   a2;
        logic [W-1:0] exp_rd1;
        logic [W-1:0] exp_rd2;
        logic [W-1:0] exp_res;
        logic         exp_wa;
    } vec_t;

    vec_t vecs[$];
    int   n_tests;
    int   n_fail;
    logic [W-1:0] mdl [0:31];

    task automatic add(input logic rst, input logic we, input logic [1:0] src,
                       input logic [W-1:0] alu, input logic [W-1:0] rdata,
                       input logic [W-1:0] pc4, input logic [4:0] rd, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [W-1:0] e1, input logic [W-1:0] e2,
                       input logic [W-1:0] er, input logic ewa);
        vec_t v;
        v.rst = rst; v.we = we; v.src = src; v.alu = alu; v.rdata = rdata; v.pc4 = pc4;
        v.rd = rd; v.a1 = a1; v.a2 = a2; v.exp_rd1 = e1; v.exp_rd2 = e2; v.exp_res = er;
        v.exp_wa = ewa;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic we, input logic [1:0] src,
                         input logic [W-1:0] alu, input logic [W-1:0] rdata,
                         input logic [W-1:0] pc4, input logic [4:0] rd, input logic [4:0] a1,
                         input logic [4:0] a2);
        reset          = rst;
        bus.RegWriteW  = we;
        bus.ResultSrcW = src;
        bus.ALUResultW = alu;
        bus.ReadDataW  = rdata;
        bus.PCPlus4W   = pc4;
        bus.RdW        = rd;
        bus.A1D        = a1;
        bus.A2D        = a2;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        drive(1'b1, 1'b0, 2'b00, '0, '0, '0, 5'd0, 5'd0, 5'd0);

        //  rst we src  alu        rdata pc4   rd  a1  a2  rd1        rd2    res        wa
        add(1, 0, 2'd0, 32'h0,     0,    0,    0,  0,  0,  0,         0,     32'h0,     0);
        add(0, 1, 2'd0, 32'h1234,  0,    0,    5,  5,  0,  32'h1234,  0,     32'h1234,  1);
        add(1, 0, 2'd0, 32'h0,     0,    0,    0,  5,  5,  0,         0,     32'h0,     0);
        add(0, 0, 2'd0, 32'h0,     0,    0,    0,  5,  5,  0,         0,     32'h0,     0);
        add(0, 1, 2'd0, 32'hA,     32'hB, 32'hC, 3, 3, 0,  32'hA,     0,     32'hA,     1);
        add(0, 0, 2'd1, 32'hA,     32'hB, 32'hC, 3, 3, 0,  32'hA,     0,     32'hB,     0);
        add(0, 1, 2'd1, 32'hA,     32'hB, 32'hC, 3, 3, 0,  32'hB,     0,     32'hB,     1);
        add(0, 0, 2'd2, 32'hA,     32'hB, 32'hC, 3, 3, 0,  32'hB,     0,     32'hC,     0);
        add(0, 1, 2'd2, 32'hA,     32'hB, 32'hC, 3, 3, 0,  32'hC,     0,     32'hC,     1);
        add(0, 0, 2'd3, 32'hA,     32'hB, 32'hC, 3, 3, 0,  32'hC,     0,     32'hA,     0);
        add(0, 1, 2'd3, 32'hA,     32'hB, 32'hC, 3, 3, 0,  32'hA,     0,     32'hA,     1);
        add(0, 0, 2'd0, 32'h0,     0,    0,    3,  3,  3,  32'hA,     32'hA, 32'h0,     0);
        add(0, 1, 2'd0, 32'hFFFFFFFF, 0, 0,    0,  0,  0,  0,         0,     32'hFFFFFFFF, 0);
        add(0, 0, 2'd0, 32'hFFFFFFFF, 0, 0,    0,  0,  0,  0,         0,     32'hFFFFFFFF, 0);
        add(0, 1, 2'd0, 32'h11,    0,    0,    7,  0,  0,  0,         0,     32'h11,    1);
        add(0, 1, 2'd0, 32'h22,    0,    0,    7,  7,  7,  32'h22,    32'h22, 32'h22,   1);
        add(0, 0, 2'd0, 32'h22,    0,    0,    7,  7,  7,  32'h22,    32'h22, 32'h22,   0);
        add(0, 1, 2'd0, 32'h1,     0,    0,    9,  9,  0,  32'h1,     0,     32'h1,     1);
        add(0, 0, 2'd0, 32'h99,    0,    0,    9,  9,  0,  32'h1,     0,     32'h99,    0);
        add(0, 0, 2'd0, 32'h99,    0,    0,    9,  9,  0,  32'h1,     0,     32'h99,    0);
        add(1, 1, 2'd0, 32'h55,    0,    0,    4,  4,  0,  0,         0,     32'h55,    0);
        add(0, 0, 2'd0, 32'h55,    0,    0,    4,  4,  4,  0,         0,     32'h55,    0);
        add(0, 1, 2'd0, 32'h66,    0,    0,    6,  6,  0,  32'h66,    0,     32'h66,    1);
        add(0, 1, 2'd0, 32'h77,    0,    0,    6,  6,  6,  32'h77,    32'h77, 32'h77,   1);
        add(0, 0, 2'd0, 32'h0,     0,    0,    6,  6,  6,  32'h77,    32'h77, 32'h0,     0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].we, vecs[i].src, vecs[i].alu, vecs[i].rdata,
                  vecs[i].pc4, vecs[i].rd, vecs[i].a1, vecs[i].a2);
            #1;
            check($sformatf("row%0d RD1D", i), bus.RD1D, vecs[i].exp_rd1);
            check($sformatf("row%0d RD2D", i), bus.RD2D, vecs[i].exp_rd2);
            check($sformatf("row%0d ResultW", i), bus.ResultW, vecs[i].exp_res);
            check($sformatf("row%0d WriteActiveW", i), {31'd0, bus.WriteActiveW},
                  {31'd0, vecs[i].exp_wa});
        end

        // Start the random phase from a known, cleared register file.
        @(negedge clk);
        drive(1'b1, 1'b0, 2'b00, '0, '0, '0, 5'd0, 5'd0, 5'd0);
        for (int r = 0; r < 32; r++) mdl[r] = '0;

        for (int i = 0; i < 400; i++) begin
            logic         rst, we, wa;
            logic [1:0]   src;
            logic [W-1:0] alu, rdata, pc4, res, e1, e2;
            logic [4:0]   rd, a1, a2;
            @(negedge clk);
            rst   = ($urandom_range(0, 31) == 0);
            we    = $urandom_range(0, 1) == 1;
            src   = 2'($urandom_range(0, 3));
            alu   = $urandom;
            rdata = $urandom;
            pc4   = $urandom;
            rd    = 5'($urandom_range(0, 7));
            a1    = 5'($urandom_range(0, 7));
            a2    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            drive(rst, we, src, alu, rdata, pc4, rd, a1, a2);

            res = (src == 2'd1) ? rdata : (src == 2'd2) ? pc4 : alu;
            wa  = we && (rd != 0) && !rst;
            e1  = rst ? '0 : (wa && a1 == rd) ? res : mdl[a1];
            e2  = rst ? '0 : (wa && a2 == rd) ? res : mdl[a2];
            #1;
            check($sformatf("rand%0d RD1D", i), bus.RD1D, e1);
            check($sformatf("rand%0d RD2D", i), bus.RD2D, e2);
            check($sformatf("rand%0d ResultW", i), bus.ResultW, res);
            check($sformatf("rand%0d WriteActiveW", i), {31'd0, bus.WriteActiveW}, {31'd0, wa});

            if (rst) begin
                for (int r = 0; r < 32; r++) mdl[r] = '0;
            end else if (wa) begin
                mdl[rd] = res;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
